sram_axi_bridge: RTL and testbench

- Converts the core's SRAM-like data port (request/addr_ok/data_ok) into single-beat AXI3 master transactions.
- Sits directly downstream of the CPU top and upstream of the AXI interconnect.
- Supports one outstanding transaction. The core stalls on addr_ok/data_ok instead of a fixed 1-cycle SRAM latency.

---
 rtl/sram_axi_bridge.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// sram_axi_bridge
//
// Purpose:
//   Turns the core's SRAM-like data port (req / addr_ok / data_ok) into
//   single-beat AXI3 master transactions. Only one transaction is in flight
//   at a time. The core stalls on addr_ok / data_ok.
//
// Port summary:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   req/wr/size/addr/
//   wdata/wstrb          core request side
//   addr_ok              request accepted this cycle (combinational)
//   data_ok              one-cycle pulse: read data valid / write complete
//   rdata                last read data, held until the next data_ok
//   ar*/r*               AXI3 read address / read data channels
//   aw*/w*/b*            AXI3 write address / write data / write response
//
// Optional build macro:
//   BRIDGE_ERR_LATCH_EN  adds bus_err (sticky SLVERR/DECERR flag) and
//                        err_addr (address of the first failing transaction).
//                        When it is not defined, response codes are ignored.
// -----------------------------------------------------------------------------
module sram_axi_bridge #(
    parameter logic [3:0]  AXI_ID = 4'd0,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef BRIDGE_ERR_LATCH_EN
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr,
`endif
    // core side
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    // AXI read address channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // AXI read data channel
    input  logic [31:0]       rdata_axi,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address channel
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // AXI write data channel
    output logic [3:0]        wid,
    output logic [31:0]       wdata_axi,
    output logic [3:0]        wstrb_axi,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // AXI write response channel
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_A  = 3'd1;
    localparam logic [2:0] ST_RD_D  = 3'd2;
    localparam logic [2:0] ST_WR_AW = 3'd3;
    localparam logic [2:0] ST_WR_B  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;
    logic [1:0]        size_q,    size_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;
    logic [31:0]       rdata_q,   rdata_d;

    logic aw_fire;
    logic w_fire;
    logic r_fire;
    logic b_fire;

    // Single-beat transfers: the last-beat flag carries no information.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, rlast, rresp, bresp};

    // ------------------------------------------------------------------
    // Outputs decoded straight from the state register, so an async reset
    // removes every valid/ready in the same instant.
    // ------------------------------------------------------------------
    assign addr_ok   = (state_q == ST_IDLE) & req;
    assign data_ok   = (state_q == ST_DONE);
    assign rdata     = rdata_q;

    assign arvalid   = (state_q == ST_RD_A);
    assign rready    = (state_q == ST_RD_D);
    assign awvalid   = (state_q == ST_WR_AW) & ~aw_done_q;
    assign wvalid    = (state_q == ST_WR_AW) & ~w_done_q;
    assign bready    = (state_q == ST_WR_B);

    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign arsize    = {1'b0, size_q};
    assign awsize    = {1'b0, size_q};
    assign wdata_axi = wdata_q;
    assign wstrb_axi = wstrb_q;
    assign wlast     = 1'b1;

    assign arid      = AXI_ID;
    assign awid      = AXI_ID;
    assign wid       = AXI_ID;
    assign arlen     = 4'd0;
    assign awlen     = 4'd0;
    assign arburst   = 2'b01;
    assign awburst   = 2'b01;
    assign arlock    = 2'b00;
    assign awlock    = 2'b00;
    assign arcache   = 4'd0;
    assign awcache   = 4'd0;
    assign arprot    = 3'd0;
    assign awprot    = 3'd0;

    assign aw_fire   = awvalid & awready;
    assign w_fire    = wvalid & wready;
    assign r_fire    = rready & rvalid;
    assign b_fire    = bready & bvalid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    size_d    = size;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr ? ST_WR_AW : ST_RD_A;
                end
            end
            ST_RD_A: begin
                if (arready) begin
                    state_d = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (rvalid) begin
                    rdata_d = rdata_axi;
                    state_d = ST_DONE;
                end
            end
            ST_WR_AW: begin
                // Address and data channels complete independently; move on
                // once both have handshaken (possibly in the same cycle).
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
                    state_d = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // addr_ok is low here, giving one dead cycle between requests.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef BRIDGE_ERR_LATCH_EN
    // ------------------------------------------------------------------
    // Sticky error capture: bit 1 of RRESP/BRESP marks SLVERR/DECERR.
    // err_addr only records the first failure after reset.
    // ------------------------------------------------------------------
    logic              bus_err_q,  bus_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              resp_err;

    assign resp_err = (r_fire & rresp[1]) | (b_fire & bresp[1]);

    always_comb begin
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        if (resp_err) begin
            bus_err_d = 1'b1;
            if (!bus_err_q) begin
                err_addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;
`else
    logic unused_fires;
    assign unused_fires = &{1'b0, r_fire, b_fire};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_axi_bridge
//
// Directed testbench for sram_axi_bridge. Each task drives one scenario,
// plays the AXI slave by hand cycle by cycle, and compares outputs against
// hand-computed values. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge. "Cycle 0" is the cycle in which
// the request is presented and accepted.
// -----------------------------------------------------------------------------
module tb_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata_axi;
    logic [3:0]  wstrb_axi;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
`ifdef BRIDGE_ERR_LATCH_EN
    logic        bus_err;
    logic [31:0] err_addr;
`endif

    int errors = 0;
    int checks = 0;

    sram_axi_bridge #(
        .AXI_ID (4'd0),
        .ADDR_W (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
`ifdef BRIDGE_ERR_LATCH_EN
        .bus_err   (bus_err),
        .err_addr  (err_addr),
`endif
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arlock    (arlock),
        .arcache   (arcache),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata_axi (rdata_axi),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awlock    (awlock),
        .awcache   (awcache),
        .awprot    (awprot),
        .awvalid   (awvalid),
        .awready   (awready),
        .wid       (wid),
        .wdata_axi (wdata_axi),
        .wstrb_axi (wstrb_axi),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_slave();
        arready   = 1'b0;
        rvalid    = 1'b0;
        rresp     = 2'b00;
        rlast     = 1'b1;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        resetn = 1'b0;
        req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0;
        wdata = 32'd0; wstrb = 4'd0; rdata_axi = 32'd0;
        idle_slave();
        #2;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, data_ok} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 000000",
                     {arvalid, awvalid, wvalid, rready, bready, data_ok});
        end
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        checks++;
        if (araddr !== 32'd0 || awaddr !== 32'd0 || wdata_axi !== 32'd0 || wstrb_axi !== 4'd0) begin
            errors++;
            $display("FAIL reset_latched: got araddr=%h awaddr=%h wdata=%h wstrb=%h expected all 0",
                     araddr, awaddr, wdata_axi, wstrb_axi);
        end
        checks++;
        if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0} ||
            {awid, awlen, awburst, awlock, awcache, awprot} !== {4'd0, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0} ||
            wid !== 4'd0 || wlast !== 1'b1) begin
            errors++;
            $display("FAIL axi_constants: got ar=%h aw=%h wid=%h wlast=%b",
                     {arid, arlen, arburst, arlock, arcache, arprot},
                     {awid, awlen, awburst, awlock, awcache, awprot}, wid, wlast);
        end
`ifdef BRIDGE_ERR_LATCH_EN
        checks++;
        if (bus_err !== 1'b0 || err_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_err: got bus_err=%b err_addr=%h expected 0/0", bus_err, err_addr);
        end
`endif
        #10 resetn = 1'b1;
        $display("test_reset: done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_read_fast();
        @(posedge clk); #1;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'hDEADBEEF;
        req = 1'b1; wr = 1'b0; addr = 32'h1FC00010; size = 2'd2;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rdfast_addr_ok_c0: got %b expected 1", addr_ok);
        end
        @(posedge clk); #1;
        req = 1'b0; addr = 32'h0; size = 2'd0;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h1FC00010 || arsize !== 3'b010 || data_ok !== 1'b0) begin
            errors++;
            $display("FAIL rdfast_ar_c1: got arvalid=%b araddr=%h arsize=%b data_ok=%b expected 1/1fc00010/010/0",
                     arvalid, araddr, arsize, data_ok);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0 || data_ok !== 1'b0) begin
            errors++;
            $display("FAIL rdfast_r_c2: got rready=%b arvalid=%b data_ok=%b expected 1/0/0",
                     rready, arvalid, data_ok);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdfast_done_c3: got data_ok=%b rdata=%h expected 1/deadbeef", data_ok, rdata);
        end
        @(posedge clk); #1;
        rdata_axi = 32'h0;
        @(negedge clk);
        checks++;
        if (data_ok !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdfast_hold_c4: got data_ok=%b rdata=%h expected 0/deadbeef", data_ok, rdata);
        end
        idle_slave();
        $display("test_read_fast: addr=1fc00010 rdata=%h", rdata);
    endtask

    // ------------------------------------------------------------------
    task automatic test_read_delayed();
        int n_ar = 0;
        int n_r  = 0;
        int n_ok = 0;
        @(posedge clk); #1;
        idle_slave();
        rdata_axi = 32'h12345678;
        req = 1'b1; wr = 1'b0; addr = 32'h00001236; size = 2'd1;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rddly_addr_ok: got %b expected 1", addr_ok);
        end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            req     = 1'b0;
            addr    = 32'hFFFFFFFF;
            arready = (cyc == 4);
            rvalid  = (cyc == 7);
            if (cyc == 9) rdata_axi = 32'hFFFF0000;
            @(negedge clk);
            if (arvalid) begin
                n_ar++;
                checks++;
                if (araddr !== 32'h00001236 || arsize !== 3'b001) begin
                    errors++;
                    $display("FAIL rddly_ar_stable c%0d: got araddr=%h arsize=%b expected 00001236/001",
                             cyc, araddr, arsize);
                end
            end
            if (rready) n_r++;
            if (data_ok) begin
                n_ok++;
                checks++;
                if (cyc != 8 || rdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL rddly_data_ok: got cycle=%0d rdata=%h expected cycle 8 rdata 12345678",
                             cyc, rdata);
                end
            end
        end
        checks++;
        if (n_ar != 4 || n_r != 3 || n_ok != 1) begin
            errors++;
            $display("FAIL rddly_counts: got arvalid=%0d rready=%0d data_ok=%0d expected 4/3/1",
                     n_ar, n_r, n_ok);
        end
        checks++;
        if (rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rddly_rdata_held: got %h expected 12345678", rdata);
        end
        idle_slave();
        $display("test_read_delayed: addr=00001236 rdata=%h ar_cycles=%0d", rdata, n_ar);
    endtask

    // ------------------------------------------------------------------
    task automatic test_write();
        @(posedge clk); #1;
        idle_slave();
        req = 1'b1; wr = 1'b1; addr = 32'h80000004; size = 2'd0;
        wdata = 32'h000000AB; wstrb = 4'b0001;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr_ok: got %b expected 1", addr_ok);
        end
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0; wr = 1'b0; wdata = 32'h0; wstrb = 4'h0; addr = 32'h0;
            wready  = (cyc == 1);
            awready = (cyc == 3);
            bvalid  = (cyc == 5);
            @(negedge clk);
            checks++;
            if (wvalid !== (cyc == 1) || awvalid !== (cyc >= 1 && cyc <= 3) ||
                bready !== (cyc == 4 || cyc == 5) || data_ok !== (cyc == 6)) begin
                errors++;
                $display("FAIL wr_handshake c%0d: got wvalid=%b awvalid=%b bready=%b data_ok=%b expected %b/%b/%b/%b",
                         cyc, wvalid, awvalid, bready, data_ok, (cyc == 1),
                         (cyc >= 1 && cyc <= 3), (cyc == 4 || cyc == 5), (cyc == 6));
            end
            if (awvalid) begin
                checks++;
                if (awaddr !== 32'h80000004 || awsize !== 3'b000) begin
                    errors++;
                    $display("FAIL wr_aw_payload c%0d: got awaddr=%h awsize=%b expected 80000004/000",
                             cyc, awaddr, awsize);
                end
            end
            if (wvalid) begin
                checks++;
                if (wdata_axi !== 32'h000000AB || wstrb_axi !== 4'b0001 || wlast !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_w_payload: got wdata=%h wstrb=%b wlast=%b expected 000000ab/0001/1",
                             wdata_axi, wstrb_axi, wlast);
                end
            end
        end
        idle_slave();
        $display("test_write: addr=80000004 wdata=000000ab wstrb=0001");
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        @(posedge clk); #1;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'hA1A1A1A1;
        req = 1'b1; wr = 1'b0; addr = 32'h00000100; size = 2'd2;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_addr_ok_c0: got %b expected 1", addr_ok);
        end
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) addr = 32'h00000200;
            if (cyc == 3) rdata_axi = 32'hB2B2B2B2;
            if (cyc == 5) req = 1'b0;
            @(negedge clk);
            checks++;
            if (addr_ok !== (cyc == 4) || data_ok !== (cyc == 3 || cyc == 7) ||
                arvalid !== (cyc == 1 || cyc == 5)) begin
                errors++;
                $display("FAIL b2b_seq c%0d: got addr_ok=%b data_ok=%b arvalid=%b expected %b/%b/%b",
                         cyc, addr_ok, data_ok, arvalid, (cyc == 4),
                         (cyc == 3 || cyc == 7), (cyc == 1 || cyc == 5));
            end
            if (cyc == 5) begin
                checks++;
                if (araddr !== 32'h00000200) begin
                    errors++;
                    $display("FAIL b2b_araddr2: got %h expected 00000200", araddr);
                end
            end
            if (cyc == 3 || cyc == 7) begin
                checks++;
                if (rdata !== ((cyc == 3) ? 32'hA1A1A1A1 : 32'hB2B2B2B2)) begin
                    errors++;
                    $display("FAIL b2b_rdata c%0d: got %h expected %h", cyc, rdata,
                             (cyc == 3) ? 32'hA1A1A1A1 : 32'hB2B2B2B2);
                end
            end
        end
        idle_slave();
        $display("test_back_to_back: reads 00000100 and 00000200 last rdata=%h", rdata);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        @(posedge clk); #1;
        arready = 1'b1; rvalid = 1'b0;
        req = 1'b1; wr = 1'b0; addr = 32'h00000044; size = 2'd2;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_rd_d: got rready=%b expected 1", rready);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_async: got arvalid=%b rready=%b data_ok=%b rdata=%h expected 0/0/0/0",
                     arvalid, rready, data_ok, rdata);
        end
        @(posedge clk); #2;
        resetn = 1'b1;
        rvalid = 1'b1; rdata_axi = 32'h5A5A5A5A;
        req = 1'b1; addr = 32'h00000088;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_addr_ok_after: got %b expected 1", addr_ok);
        end
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0;
            @(negedge clk);
            if (cyc == 3) begin
                checks++;
                if (data_ok !== 1'b1 || rdata !== 32'h5A5A5A5A) begin
                    errors++;
                    $display("FAIL rstmid_recover: got data_ok=%b rdata=%h expected 1/5a5a5a5a",
                             data_ok, rdata);
                end
            end
        end
        idle_slave();
        $display("test_reset_mid: recovered read rdata=%h", rdata);
    endtask

    // ------------------------------------------------------------------
    task automatic test_illegal_size();
        @(posedge clk); #1;
        arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'h0BADF00D;
        req = 1'b1; wr = 1'b0; addr = 32'h00000003; size = 2'd3;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || arsize !== 3'b011 || araddr !== 32'h00000003) begin
            errors++;
            $display("FAIL illegal_size: got arvalid=%b arsize=%b araddr=%h expected 1/011/00000003",
                     arvalid, arsize, araddr);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_slave();
        $display("test_illegal_size: arsize forwarded, rdata=%h", rdata);
    endtask

`ifdef BRIDGE_ERR_LATCH_EN
    // ------------------------------------------------------------------
    task automatic test_err_latch();
        // failing write
        @(posedge clk); #1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        req = 1'b1; wr = 1'b1; addr = 32'hBFAF0000; size = 2'd2;
        wdata = 32'h11223344; wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got bus_err=%b expected 0", bus_err);
        end
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0; wr = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (data_ok !== 1'b1 || bus_err !== 1'b1 || err_addr !== 32'hBFAF0000) begin
            errors++;
            $display("FAIL err_write: got data_ok=%b bus_err=%b err_addr=%h expected 1/1/bfaf0000",
                     data_ok, bus_err, err_addr);
        end
        idle_slave();
        // OKAY read, then a failing read to a second address
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            arready = 1'b1; rvalid = 1'b1; rresp = (t == 0) ? 2'b00 : 2'b11;
            req = 1'b1; wr = 1'b0; addr = (t == 0) ? 32'h00000010 : 32'h00000020;
            for (int cyc = 1; cyc <= 3; cyc++) begin
                @(posedge clk); #1;
                req = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (data_ok !== 1'b1 || bus_err !== 1'b1 || err_addr !== 32'hBFAF0000) begin
                errors++;
                $display("FAIL err_sticky t%0d: got data_ok=%b bus_err=%b err_addr=%h expected 1/1/bfaf0000",
                         t, data_ok, bus_err, err_addr);
            end
            idle_slave();
        end
        $display("test_err_latch: bus_err=%b err_addr=%h", bus_err, err_addr);
    endtask
`endif

    initial begin
        test_reset();
        test_read_fast();
        test_read_delayed();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_illegal_size();
`ifdef BRIDGE_ERR_LATCH_EN
        test_err_latch();
`endif
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
